// File: rtl/sigmon_report_pkg.sv
// -----------------------------------------------------------------------------
// sigmon_report_pkg
// Shared definitions for the Sigmon report transmitter: record/beat geometry,
// header field offsets, the TX FSM state type and the record assembly helper.
// No ports (package).
// -----------------------------------------------------------------------------
package sigmon_report_pkg;

   localparam int BEAT_W   = 64;
   localparam int BEATS    = 4;
   localparam int REC_W    = BEAT_W * BEATS;   // 256-bit record
   localparam int NPAT     = 4;                // pattern units
   localparam int SAMPLE_W = 48;               // sample width per pattern

   // Header beat (beat 0) field offsets
   localparam int HDR_SAMPLE_LSB = 0;
   localparam int HDR_MATCH_LSB  = 4;
   localparam int HDR_PAD_LSB    = 8;
   localparam int HDR_SEQ_LSB    = 16;
   localparam int HDR_TS_LSB     = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      BEAT0 = 3'd1,
      BEAT1 = 3'd2,
      BEAT2 = 3'd3,
      BEAT3 = 3'd4
   } tx_state_t;

   // Assemble one record: header in bits [63:0], then the four sample lanes
   // packed contiguously from bit 64 upward. Lanes without a sample are zero.
   function automatic logic [REC_W-1:0] build_record(
      input logic [31:0]              ts,
      input logic [15:0]              seq,
      input logic [NPAT-1:0]          match,
      input logic [NPAT-1:0]          sample,
      input logic [NPAT*SAMPLE_W-1:0] data
   );
      logic [REC_W-1:0] rec;
      rec = {REC_W{1'b0}};
      rec[HDR_SAMPLE_LSB +: NPAT] = sample;
      rec[HDR_MATCH_LSB  +: NPAT] = match;
      rec[HDR_PAD_LSB    +: 8]    = 8'h00;
      rec[HDR_SEQ_LSB    +: 16]   = seq;
      rec[HDR_TS_LSB     +: 32]   = ts;
      for (int i = 0; i < NPAT; i++) begin
         if (sample[i]) begin
            rec[BEAT_W + SAMPLE_W*i +: SAMPLE_W] = data[SAMPLE_W*i +: SAMPLE_W];
         end else begin
            rec[BEAT_W + SAMPLE_W*i +: SAMPLE_W] = {SAMPLE_W{1'b0}};
         end
      end
      return rec;
   endfunction

endpackage

// File: rtl/sigmon_report_fifo.sv
// -----------------------------------------------------------------------------
// sigmon_report_fifo
// Synchronous record FIFO with wrap-bit pointers. A push while full is taken
// when a pop completes in the same cycle. Besides the head it exposes the entry
// behind the head so the transmitter can chain records without an idle cycle.
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_push, i_wdata    write request / record
//   i_pop              remove head
//   o_full, o_empty    status
//   o_multi            at least two entries held
//   o_rdata            head record
//   o_rdata_next       record behind the head (valid when o_multi)
// -----------------------------------------------------------------------------
module sigmon_report_fifo #(
   parameter int WIDTH = 256,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_wdata,
   output logic             o_full,
   output logic             o_empty,
   output logic             o_multi,
   output logic [WIDTH-1:0] o_rdata,
   output logic [WIDTH-1:0] o_rdata_next
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic [AW:0]      w_count;
   logic [AW:0]      w_rptr_next;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_count      = r_wptr - r_rptr;
   assign w_rptr_next  = r_rptr + PTR_ONE;
   assign o_empty      = (r_wptr == r_rptr);
   assign o_full       = (r_wptr[AW] != r_rptr[AW]) &&
                         (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign o_multi      = (w_count > PTR_ONE);
   assign w_do_pop     = i_pop & ~o_empty;
   assign w_do_push    = i_push & (~o_full | w_do_pop);
   assign o_rdata      = r_mem[r_rptr[AW-1:0]];
   assign o_rdata_next = r_mem[w_rptr_next[AW-1:0]];

   // Record storage (no reset needed: pointers define validity)
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wptr[AW-1:0]] <= i_wdata;
      end
   end

   // Read/write pointers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wptr <= {(AW+1){1'b0}};
         r_rptr <= {(AW+1){1'b0}};
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + PTR_ONE;
         end
         if (w_do_pop) begin
            r_rptr <= w_rptr_next;
         end
      end
   end

endmodule

// File: rtl/sigmon_report_tx.sv
// -----------------------------------------------------------------------------
// sigmon_report_tx
// Collects eop-aligned match/sample events from four pattern units, stamps them
// with a free-running timestamp and a sequence number, buffers them as 256-bit
// records and sends each record as a 4-beat 64-bit AXI4-Stream packet.
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_report_enable         events ignored while low
//   i_match_event_in[3:0]   per-pattern match pulse
//   i_sample_event_in[3:0]  per-pattern sample pulse
//   i_sample_data_in[191:0] pattern i sample at [48i+47:48i]
//   i_drop_clear            pulse, clears the drop counter
//   o_out_tvalid/i_out_tready/o_out_tdata/o_out_tlast  AXI4-Stream master
//   o_drop_count[15:0]      saturating count of records lost to a full buffer
//   o_seq_num[15:0]         sequence number the next event will receive
// -----------------------------------------------------------------------------
module sigmon_report_tx
   import sigmon_report_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_report_enable,
   input  logic [NPAT-1:0]          i_match_event_in,
   input  logic [NPAT-1:0]          i_sample_event_in,
   input  logic [NPAT*SAMPLE_W-1:0] i_sample_data_in,
   input  logic                     i_drop_clear,
   output logic                     o_out_tvalid,
   input  logic                     i_out_tready,
   output logic [BEAT_W-1:0]        o_out_tdata,
   output logic                     o_out_tlast,
   output logic [15:0]              o_drop_count,
   output logic [15:0]              o_seq_num
);

   tx_state_t                 r_state;
   logic [31:0]               r_ts;
   logic [15:0]               r_seq;
   logic [15:0]               r_drop;
   logic [REC_W-1:BEAT_W]     r_rest;     // beats 1..3 of the record in flight
   logic                      r_tvalid;
   logic [BEAT_W-1:0]         r_tdata;
   logic                      r_tlast;

   logic                      w_event;
   logic                      w_hs;
   logic                      w_pop;
   logic                      w_full;
   logic                      w_empty;
   logic                      w_multi;
   logic                      w_push_ok;
   logic                      w_drop;
   logic                      w_have_next;
   logic [REC_W-1:0]          w_record;
   logic [REC_W-1:0]          w_head;
   logic [REC_W-1:0]          w_after_head;
   logic [REC_W-1:0]          w_next_rec;

   assign w_event   = i_report_enable & (|(i_match_event_in | i_sample_event_in));
   assign w_hs      = r_tvalid & i_out_tready;
   assign w_pop     = (r_state == BEAT3) & w_hs;
   assign w_push_ok = w_event & (~w_full | w_pop);
   assign w_drop    = w_event & ~w_push_ok;
   assign w_record  = build_record(r_ts, r_seq, i_match_event_in,
                                   i_sample_event_in, i_sample_data_in);

   sigmon_report_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_push       (w_event),
      .i_pop        (w_pop),
      .i_wdata      (w_record),
      .o_full       (w_full),
      .o_empty      (w_empty),
      .o_multi      (w_multi),
      .o_rdata      (w_head),
      .o_rdata_next (w_after_head)
   );

   // Record to chain after the head is popped: the entry behind the head, or
   // (when the head is the only entry) the record being pushed this cycle.
   always_comb begin
      w_next_rec  = w_after_head;
      w_have_next = 1'b0;
      if (w_multi) begin
         w_next_rec  = w_after_head;
         w_have_next = 1'b1;
      end else begin
         w_next_rec  = w_record;
         w_have_next = w_push_ok;
      end
   end

   // Free-running timestamp
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_ts <= 32'd0;
      end else begin
         r_ts <= r_ts + 32'd1;
      end
   end

   // Sequence number advances on every event cycle, dropped or not
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_seq <= 16'd0;
      end else if (w_event) begin
         r_seq <= r_seq + 16'd1;
      end
   end

   // Saturating drop counter; a clear coinciding with a drop leaves 1
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_drop <= 16'd0;
      end else if (i_drop_clear) begin
         r_drop <= w_drop ? 16'd1 : 16'd0;
      end else if (w_drop && (r_drop != 16'hFFFF)) begin
         r_drop <= r_drop + 16'd1;
      end
   end

   // TX FSM and registered stream outputs
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= IDLE;
         r_tvalid <= 1'b0;
         r_tdata  <= {BEAT_W{1'b0}};
         r_tlast  <= 1'b0;
         r_rest   <= {(REC_W-BEAT_W){1'b0}};
      end else begin
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_rest   <= w_head[REC_W-1:BEAT_W];
                  r_tdata  <= w_head[BEAT_W-1:0];
                  r_tvalid <= 1'b1;
                  r_tlast  <= 1'b0;
                  r_state  <= BEAT0;
               end
            end
            BEAT0: begin
               if (w_hs) begin
                  r_tdata <= r_rest[2*BEAT_W-1:BEAT_W];
                  r_state <= BEAT1;
               end
            end
            BEAT1: begin
               if (w_hs) begin
                  r_tdata <= r_rest[3*BEAT_W-1:2*BEAT_W];
                  r_state <= BEAT2;
               end
            end
            BEAT2: begin
               if (w_hs) begin
                  r_tdata <= r_rest[4*BEAT_W-1:3*BEAT_W];
                  r_tlast <= 1'b1;
                  r_state <= BEAT3;
               end
            end
            BEAT3: begin
               if (w_hs) begin
                  if (w_have_next) begin
                     r_rest   <= w_next_rec[REC_W-1:BEAT_W];
                     r_tdata  <= w_next_rec[BEAT_W-1:0];
                     r_tvalid <= 1'b1;
                     r_tlast  <= 1'b0;
                     r_state  <= BEAT0;
                  end else begin
                     r_tvalid <= 1'b0;
                     r_tlast  <= 1'b0;
                     r_state  <= IDLE;
                  end
               end
            end
            default: begin
               r_tvalid <= 1'b0;
               r_tlast  <= 1'b0;
               r_state  <= IDLE;
            end
         endcase
      end
   end

   assign o_out_tvalid = r_tvalid;
   assign o_out_tdata  = r_tdata;
   assign o_out_tlast  = r_tlast;
   assign o_drop_count = r_drop;
   assign o_seq_num    = r_seq;

endmodule

// File: doc/sigmon_report_tx.md
# sigmon_report_tx

Sigmon report transmitter: the producer end of the Sigmon event path. It collects per-packet match/sample events from four pattern units, timestamps and sequence-numbers them, and buffers them as records. It transmits each record to the host-bound AXI4-Stream as a 4-beat, 64-bit packet. It sits downstream of the pattern units and upstream of the report DMA/stream mux.

## Interface
- FIFO_DEPTH, 4, record buffer depth; power of two, >= 2
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high reset
- report_enable  in  1  level; events ignored while low
- match_event_in  in  4  per-pattern match pulse, eop-aligned, bit i = pattern i
- sample_event_in  in  4  per-pattern sample pulse, eop-aligned
- sample_data_in  in  192  pattern i sample at [48i+47:48i], valid with its sample pulse
- drop_clear  in  1  pulse; clears drop_count
- out_tvalid  out  1  AXI4-Stream valid
- out_tready  in  1  AXI4-Stream ready
- out_tdata  out  64  record beat
- out_tlast  out  1  high on beat 3 of each record
- drop_count  out  16  saturating count of records lost to a full buffer
- seq_num  out  16  sequence number the next event cycle will receive

## Operation
- Event cycle: report_enable high and (match_event_in | sample_event_in) != 0.
- Each event cycle forms one 256-bit record:
  - Header beat 0: {timestamp[31:0], seq[15:0], 8'h00, match[3:0], sample[3:0]}.
  - Beats 1..3 hold sample data as {s1[15:0], s0[47:0]}, {s2[31:0], s1[47:16]}, {s3[47:0], s2[47:32]}.
  - Lane i is zeroed when sample bit i is 0.
- Timestamp: free-running 32-bit counter. It is 0 in the first cycle after reset and wraps at 2^32. The record takes the value of its event cycle.
- seq increments by 1 mod 2^16 on every event cycle, including dropped ones, so the host detects gaps.
- Buffer full at an event cycle: the record is dropped and drop_count increments, saturating at 16'hFFFF.
  - Exception: if a record pop completes in the same cycle, the push is accepted.
- drop_clear sets drop_count to 0. If a drop coincides with drop_clear, the result is 1.
- TX FSM:
  - IDLE: when the buffer is non-empty, load the head record into the output register and go to BEAT0.
  - BEAT0 -> BEAT1 -> BEAT2 -> BEAT3: each state advances on out_tvalid & out_tready.
  - BEAT3 & handshake: pop the head. If the buffer is still non-empty, load the next record and go to BEAT0 (back-to-back, no idle cycle). Otherwise go to IDLE.
- AXI rules:
  - out_tvalid is high in all BEAT states.
  - out_tdata and out_tlast are stable while out_tvalid & ~out_tready.
  - out_tvalid never drops mid-record.
- report_enable falling mid-record has no effect on records already buffered or in flight.

## Timing
- Reset values: out_tvalid 0, out_tdata 0, out_tlast 0, drop_count 0, seq_num 0. FSM goes to IDLE, buffer empty, timestamp 0.
- Reset asserted mid-record aborts it. out_tvalid is 0 in the cycle after the reset edge, and partial records are discarded.
- Latency: event in cycle t with an empty buffer and an IDLE FSM gives a record write at the edge ending t, and out_tvalid high with beat 0 in cycle t+2.
- With out_tready held high, one record takes 4 cycles. Sustained throughput is 1 record per 4 cycles.
- seq_num reflects an increment in the cycle after the event cycle.

## Structure
- Package sigmon_report_pkg:
  - REC_W = 256, BEAT_W = 64, BEATS = 4.
  - Header field offsets.
  - FSM state enum {IDLE, BEAT0, BEAT1, BEAT2, BEAT3}.
- Sub-module sigmon_report_fifo: synchronous FIFO, REC_W wide, FIFO_DEPTH deep.
  - Ports: push, pop, full, empty, wdata, rdata.
  - Pointers have one extra wrap bit.
  - Push is allowed when full & pop.
- Top level holds the timestamp, seq and drop counters, record assembly, and the TX FSM/output register.

## Test plan
- Single record: reset, out_tready=1. Cycle 5: match_event_in=4'b0001, sample_event_in=4'b0010, s1=48'h112233445566.
  - Expect 4 beats starting cycle 7.
  - Beat 0 = {32'd5, 16'd0, 8'h00, 4'h1, 4'h2}.
  - Beat 1 = {16'h5566, 48'h0}.
  - Beat 2 = {32'h0, 32'h11223344}.
  - Beat 3 = 64'h0, with out_tlast set.
- Backpressure: out_tready toggles 1/0 each cycle.
  - out_tdata is unchanged across every stalled cycle.
  - The record completes in 8 cycles.
  - out_tvalid stays high throughout.
- Overflow: out_tready=0, 6 consecutive event cycles with FIFO_DEPTH=4.
  - drop_count=2 and seq_num=6.
  - Releasing out_tready yields records with seq 0,1,2,3 back-to-back, 16 beats with no valid gap.
- Full plus simultaneous pop: buffer full, and an event coincides with a beat-3 handshake. The event is accepted and drop_count is unchanged.
- Saturation and clear:
  - Force 65537 drops: drop_count=16'hFFFF.
  - drop_clear alone gives 0.
  - drop_clear coinciding with a drop gives 1.
- Reset mid-record: assert reset during beat 2 while 2 records are buffered.
  - out_tvalid=0 the next cycle and the buffer is empty.
  - The next event after reset carries seq 0.
